// File: rtl/debounce_bank.sv
// Multi-channel debouncer: two-flop synchroniser, shared sample prescaler,
// per-channel stability counters and registered rise/fall/changed pulses.
module debounce_bank #(
  parameter int   CH     = 8,
  parameter int   DIV    = 125_000,
  parameter int   STABLE = 8,
  parameter logic INIT   = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] noisy,
  output logic [CH-1:0] clean,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          changed
);

  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCW = $clog2(STABLE + 1);

  logic [CH-1:0]  sync1;
  logic [CH-1:0]  sync2;
  logic [CW-1:0]  cnt;
  logic           tick;
  logic [SCW-1:0] sc [CH];
  logic [CH-1:0]  commit;

  assign tick = (cnt == CW'(DIV - 1));

  // A channel commits on the tick that delivers its STABLE-th consecutive
  // disagreeing sample; everything downstream keys off this vector.
  always_comb begin
    commit = '0;
    for (int i = 0; i < CH; i++) begin
      commit[i] = tick && (sync2[i] != clean[i]) && (sc[i] == SCW'(STABLE - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= {CH{INIT}};
      sync2   <= {CH{INIT}};
      cnt     <= '0;
      clean   <= {CH{INIT}};
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        sc[i] <= '0;
      end
    end else begin
      sync1 <= noisy;
      sync2 <= sync1;

      if (tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      // Any agreeing sample, or a commit, restarts the count from zero.
      for (int i = 0; i < CH; i++) begin
        if (tick) begin
          if ((sync2[i] == clean[i]) || commit[i]) begin
            sc[i] <= '0;
          end else begin
            sc[i] <= sc[i] + SCW'(1);
          end
        end
      end

      clean   <= clean ^ commit;
      rise    <= commit & sync2;
      fall    <= commit & ~sync2;
      changed <= |commit;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised and directed bench for debounce_bank (CH=4, DIV=4, STABLE=3),
// checking INIT=0 and INIT=1 instances against a sample-history model.
module tb_debounce_bank;

  localparam int CH     = 4;
  localparam int DIV    = 4;
  localparam int STABLE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] noisy = '0;

  logic [CH-1:0] clean0, rise0, fall0;
  logic          changed0;
  logic [CH-1:0] clean1, rise1, fall1;
  logic          changed1;

  int checks = 0;
  int errors = 0;

  debounce_bank #(.CH(CH), .DIV(DIV), .STABLE(STABLE), .INIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .noisy(noisy),
    .clean(clean0), .rise(rise0), .fall(fall0), .changed(changed0)
  );

  debounce_bank #(.CH(CH), .DIV(DIV), .STABLE(STABLE), .INIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .noisy(noisy),
    .clean(clean1), .rise(rise1), .fall(fall1), .changed(changed1)
  );

  always #5 clk = ~clk;

  // Reference: history of applied inputs, tick counted as edges since reset,
  // and a run length of consecutive disagreeing samples per channel.
  logic [CH-1:0] hist [$];
  int            edges;
  logic [CH-1:0] m_clean [2];
  logic [CH-1:0] m_rise  [2];
  logic [CH-1:0] m_fall  [2];
  logic          m_chg   [2];
  int            m_run   [2][CH];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelStep(input logic [CH-1:0] n, input logic r);
    logic [CH-1:0] samp;
    logic          tk;
    if (r) begin
      hist.delete();
      edges = 0;
      for (int d = 0; d < 2; d++) begin
        m_clean[d] = (d == 1) ? {CH{1'b1}} : {CH{1'b0}};
        m_rise[d]  = '0;
        m_fall[d]  = '0;
        m_chg[d]   = 1'b0;
        for (int c = 0; c < CH; c++) m_run[d][c] = 0;
      end
    end else begin
      edges++;
      tk = ((edges % DIV) == 0);
      for (int d = 0; d < 2; d++) begin
        samp = (hist.size() == 2) ? hist[0] : ((d == 1) ? {CH{1'b1}} : {CH{1'b0}});
        m_rise[d] = '0;
        m_fall[d] = '0;
        if (tk) begin
          for (int c = 0; c < CH; c++) begin
            if (samp[c] == m_clean[d][c]) begin
              m_run[d][c] = 0;
            end else begin
              m_run[d][c]++;
              if (m_run[d][c] == STABLE) begin
                m_clean[d][c] = samp[c];
                m_rise[d][c]  = samp[c];
                m_fall[d][c]  = ~samp[c];
                m_run[d][c]   = 0;
              end
            end
          end
        end
        m_chg[d] = |(m_rise[d] | m_fall[d]);
      end
      hist.push_back(n);
      if (hist.size() > 2) void'(hist.pop_front());
    end
  endtask

  task automatic compareAll();
    checkOutput("clean0",   32'(clean0),   32'(m_clean[0]));
    checkOutput("rise0",    32'(rise0),    32'(m_rise[0]));
    checkOutput("fall0",    32'(fall0),    32'(m_fall[0]));
    checkOutput("changed0", 32'(changed0), 32'(m_chg[0]));
    checkOutput("clean1",   32'(clean1),   32'(m_clean[1]));
    checkOutput("rise1",    32'(rise1),    32'(m_rise[1]));
    checkOutput("fall1",    32'(fall1),    32'(m_fall[1]));
    checkOutput("changed1", 32'(changed1), 32'(m_chg[1]));
  endtask

  task automatic applyStimulus(input logic [CH-1:0] n, input logic r);
    noisy = n;
    rst   = r;
    @(posedge clk);
    modelStep(n, r);
    #1;
    compareAll();
  endtask

  logic [CH-1:0] cur;
  logic          sticky;
  logic          found;
  int            lat;
  int            rate;

  initial begin
    // Reset with all inputs high; outputs must stay at reset values.
    for (int k = 0; k < 3; k++) applyStimulus(4'hF, 1'b1);
    applyStimulus(4'h0, 1'b0);
    checkOutput("post_reset_clean0", 32'(clean0), 32'h0);
    checkOutput("post_reset_clean1", 32'(clean1), 32'hF);
    for (int k = 0; k < 20; k++) applyStimulus(4'h0, 1'b0);

    // Sustained rise on channel 0 commits inside the latency window.
    found = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      applyStimulus(4'b0001, 1'b0);
      if (clean0[0]) begin
        found = 1'b1;
        lat   = k;
        checkOutput("rise_pulse", 32'(rise0), 32'h1);
      end
    end
    checkOutput("rise_latency_ok", 32'(found && lat >= 11 && lat <= 15), 32'h1);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("rise_one_cycle", 32'(rise0), 32'h0);

    // Fast toggling on channel 1 is filtered out entirely.
    sticky = 1'b0;
    for (int k = 0; k < 200; k++) begin
      applyStimulus({2'b00, 1'((k / 5) % 2), 1'b1}, 1'b0);
      sticky = sticky | rise0[1] | fall0[1];
    end
    checkOutput("toggle_clean1", 32'(clean0[1]), 32'h0);
    checkOutput("toggle_no_pulse", 32'(sticky), 32'h0);

    // A short low glitch on a settled high channel 2 is ignored.
    for (int k = 0; k < 30; k++) applyStimulus(4'b0101, 1'b0);
    checkOutput("glitch_pre", 32'(clean0[2]), 32'h1);
    sticky = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'b0001, 1'b0);
      sticky = sticky | fall0[2];
    end
    for (int k = 0; k < 30; k++) begin
      applyStimulus(4'b0101, 1'b0);
      sticky = sticky | fall0[2];
    end
    checkOutput("glitch_clean2", 32'(clean0[2]), 32'h1);
    checkOutput("glitch_no_fall", 32'(sticky), 32'h0);

    // Simultaneous commits on four channels land in one cycle.
    for (int k = 0; k < 30; k++) applyStimulus(4'b0011, 1'b0);
    checkOutput("simul_pre", 32'(clean0), 32'h3);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      applyStimulus(4'b1100, 1'b0);
      if (changed0) begin
        found = 1'b1;
        checkOutput("simul_rise", 32'(rise0), 32'hC);
        checkOutput("simul_fall", 32'(fall0), 32'h3);
        checkOutput("simul_clean", 32'(clean0), 32'hC);
      end
    end
    checkOutput("simul_seen", 32'(found), 32'h1);
    for (int k = 0; k < 10; k++) applyStimulus(4'b1100, 1'b0);
    checkOutput("simul_after", 32'(clean0), 32'hC);

    // Reset in the middle of a pending count restarts the full latency.
    for (int k = 0; k < 10; k++) applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("midreset_clean0", 32'(clean0), 32'h0);
    checkOutput("midreset_clean1", 32'(clean1), 32'hF);
    found = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      applyStimulus(4'b0001, 1'b0);
      if (clean0[0]) begin
        found = 1'b1;
        lat   = k;
      end
    end
    checkOutput("midreset_latency_ok", 32'(found && lat >= 11 && lat <= 15), 32'h1);

    // Random phase: bursts of varying toggle density and rare resets.
    cur  = '0;
    rate = 4;
    for (int k = 0; k < 4000; k++) begin
      if ((k % 200) == 0) rate = $urandom_range(2, 40);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(rate - 1, 0) == 0) cur[c] = ~cur[c];
      end
      applyStimulus(cur, ($urandom_range(599, 0) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
